// File: rtl/rat_interrupt_controller.sv
// Multi-source interrupt controller for the RAT MCU: edge capture, mask, fixed-priority
// select, and a request/service handshake with the control unit, all visible on the I/O ports.
module rat_interrupt_controller #(
  parameter int unsigned N_SRC      = 4,
  parameter logic [7:0]  MASK_PORT  = 8'h40,
  parameter logic [7:0]  STAT_PORT  = 8'h41,
  parameter logic [7:0]  CLR_PORT   = 8'h42,
  parameter logic [7:0]  CAUSE_PORT = 8'h43
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic [N_SRC-1:0] IRQ,
  input  logic             INT_ACK,
  input  logic             EOI,
  input  logic [7:0]       PORT_ID,
  input  logic [7:0]       OUT_PORT,
  input  logic             IO_STRB,
  output logic [7:0]       IN_PORT,
  output logic             INTR
);

  typedef enum logic [1:0] {StIdle, StReq, StServ} state_e;

  state_e           state_q, state_d;
  logic [N_SRC-1:0] s1_q, s2_q, s3_q;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] edge_det, active, cause_oh, ack_clr, clr_bits;
  logic [1:0]       cause_q, cause_d, win;
  logic             cause_live, mask_wr, clr_wr;
  logic [7:0]       mask8;
  logic [3:0]       pend4;
  logic             unused_out;

  assign unused_out = ^OUT_PORT;

  assign edge_det = s2_q & ~s3_q;
  assign active   = pend_q & mask_q;
  assign mask_wr  = IO_STRB && (PORT_ID == MASK_PORT);
  assign clr_wr   = IO_STRB && (PORT_ID == CLR_PORT);
  assign clr_bits = clr_wr ? OUT_PORT[N_SRC-1:0] : '0;

  // One-hot view of the frozen cause, built by compare so N_SRC < 4 never indexes out of range.
  always_comb begin
    cause_oh = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (cause_q == 2'(i)) cause_oh[i] = 1'b1;
    end
  end

  assign cause_live = |(cause_oh & active);

  // Lowest index wins: scan downward so the last hit is the smallest index.
  always_comb begin
    win = '0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (active[i]) win = 2'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    ack_clr = '0;
    case (state_q)
      StIdle: begin
        if (|active) begin
          state_d = StReq;
          cause_d = win;
        end
      end
      StReq: begin
        if (INT_ACK) begin
          state_d = StServ;
          ack_clr = cause_oh;
        end else if (!cause_live) begin
          state_d = StIdle;
        end
      end
      StServ: begin
        if (EOI) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // A fresh edge must survive a coincident ack or software clear.
  assign pend_d = (pend_q & ~ack_clr & ~clr_bits) | edge_det;
  assign mask_d = mask_wr ? OUT_PORT[N_SRC-1:0] : mask_q;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      mask_q  <= '0;
      pend_q  <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      s1_q    <= IRQ;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      cause_q <= cause_d;
    end
  end

  assign INTR = (state_q == StReq);

  always_comb begin
    mask8 = '0;
    pend4 = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      mask8[i] = mask_q[i];
      pend4[i] = pend_q[i];
    end
  end

  always_comb begin
    IN_PORT = 8'h00;
    if (PORT_ID == MASK_PORT) begin
      IN_PORT = mask8;
    end else if (PORT_ID == STAT_PORT) begin
      IN_PORT = {state_q == StServ, state_q == StReq, 2'b00, pend4};
    end else if (PORT_ID == CAUSE_PORT) begin
      IN_PORT = {6'b0, cause_q};
    end
  end

endmodule

// File: tb/tb_rat_interrupt_controller.sv
// Directed bench for rat_interrupt_controller: stimulus queues expected port/INTR values,
// a monitor pops and compares them when a check strobe is raised mid-cycle.
module tb_rat_interrupt_controller;

  localparam logic [7:0] MaskPort  = 8'h40;
  localparam logic [7:0] StatPort  = 8'h41;
  localparam logic [7:0] ClrPort   = 8'h42;
  localparam logic [7:0] CausePort = 8'h43;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] irq;
  logic       int_ack, eoi, io_strb;
  logic [7:0] port_id, out_port, in_port;
  logic       intr;
  logic       chk_valid = 1'b0;

  typedef struct {
    string      name;
    logic [7:0] din;
    logic       intr;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  rat_interrupt_controller dut (
    .clk      (clk),
    .RESET    (rst),
    .IRQ      (irq),
    .INT_ACK  (int_ack),
    .EOI      (eoi),
    .PORT_ID  (port_id),
    .OUT_PORT (out_port),
    .IO_STRB  (io_strb),
    .IN_PORT  (in_port),
    .INTR     (intr)
  );

  always #10 clk = ~clk;

  // Monitor: compares DUT outputs against the oldest queued expectation.
  always @(posedge chk_valid) begin
    exp_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL monitor: check strobe with empty expectation queue");
    end else begin
      e = exp_q.pop_front();
      if (in_port !== e.din || intr !== e.intr) begin
        fails++;
        $display("FAIL %s: got in_port=%h intr=%b, expected in_port=%h intr=%b",
                 e.name, in_port, intr, e.din, e.intr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] port, input logic [7:0] din,
                     input logic ex_intr);
    exp_t e;
    e.name = name;
    e.din  = din;
    e.intr = ex_intr;
    port_id = port;
    exp_q.push_back(e);
    #1 chk_valid = 1'b1;
    #1 chk_valid = 1'b0;
  endtask

  task automatic wr(input logic [7:0] port, input logic [7:0] data);
    port_id  = port;
    out_port = data;
    io_strb  = 1'b1;
    tick(1);
    io_strb  = 1'b0;
  endtask

  task automatic ack();
    int_ack = 1'b1;
    tick(1);
    int_ack = 1'b0;
  endtask

  task automatic end_svc();
    eoi = 1'b1;
    tick(1);
    eoi = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq = '0; int_ack = 0; eoi = 0; io_strb = 0; port_id = '0; out_port = '0;
    tick(2);
    rst = 1'b0;
    tick(1);

    // Reset while a request is posted
    wr(MaskPort, 8'h01);
    irq = 4'b0001;
    tick(4);
    chk("rst_pre_req", StatPort, 8'h41, 1'b1);
    rst = 1'b1;
    irq = '0;
    chk("rst_immediate", StatPort, 8'h00, 1'b0);
    tick(1);
    rst = 1'b0;
    tick(1);
    chk("rst_mask", MaskPort, 8'h00, 1'b0);
    chk("rst_stat", StatPort, 8'h00, 1'b0);
    chk("rst_cause", CausePort, 8'h00, 1'b0);

    // Single source, 3-cycle pulse
    wr(MaskPort, 8'h01);
    irq = 4'b0001;
    tick(1);
    chk("single_k", StatPort, 8'h00, 1'b0);
    tick(1);
    chk("single_k1", StatPort, 8'h00, 1'b0);
    tick(1);
    chk("single_k2", StatPort, 8'h01, 1'b0);
    irq = '0;
    tick(1);
    chk("single_k3", StatPort, 8'h41, 1'b1);
    chk("single_cause", CausePort, 8'h00, 1'b1);
    ack();
    chk("single_ack", StatPort, 8'h80, 1'b0);
    end_svc();
    chk("single_eoi", StatPort, 8'h00, 1'b0);
    tick(3);
    chk("single_quiet", StatPort, 8'h00, 1'b0);
    chk("unmapped_port", 8'h44, 8'h00, 1'b0);

    // Priority: sources 3 and 1 together
    wr(MaskPort, 8'h0F);
    chk("mask_rd", MaskPort, 8'h0F, 1'b0);
    irq = 4'b1010;
    tick(3);
    chk("prio_pend", StatPort, 8'h0A, 1'b0);
    irq = '0;
    tick(1);
    chk("prio_cause1", CausePort, 8'h01, 1'b1);
    chk("prio_stat_req", StatPort, 8'h4A, 1'b1);
    ack();
    chk("prio_serv", StatPort, 8'h88, 1'b0);
    end_svc();
    chk("prio_idle", StatPort, 8'h08, 1'b0);
    tick(1);
    chk("prio_cause3", CausePort, 8'h03, 1'b1);
    ack();
    end_svc();
    chk("prio_done", StatPort, 8'h00, 1'b0);

    // Masking
    wr(MaskPort, 8'h00);
    irq = 4'b0100;
    tick(3);
    irq = '0;
    tick(2);
    chk("mask_pend_only", StatPort, 8'h04, 1'b0);
    wr(MaskPort, 8'h04);
    chk("mask_wr_edge", StatPort, 8'h04, 1'b0);
    tick(1);
    chk("mask_req", StatPort, 8'h44, 1'b1);
    wr(MaskPort, 8'h00);
    chk("unmask_still_req", StatPort, 8'h44, 1'b1);
    tick(1);
    chk("unmask_drop", StatPort, 8'h04, 1'b0);
    wr(ClrPort, 8'h0F);
    chk("clr_all", StatPort, 8'h00, 1'b0);

    // Software clear colliding with a new edge
    irq = 4'b0001;
    tick(2);
    wr(ClrPort, 8'h01);
    chk("clr_vs_edge", StatPort, 8'h01, 1'b0);
    irq = '0;
    wr(ClrPort, 8'h01);
    chk("clr_plain", StatPort, 8'h00, 1'b0);

    // Ack colliding with a new edge on the cause bit
    wr(MaskPort, 8'h01);
    irq = 4'b0001;
    tick(3);
    irq = '0;
    tick(1);
    chk("ackcol_req", StatPort, 8'h41, 1'b1);
    tick(3);
    irq = 4'b0001;
    tick(2);
    ack();
    irq = '0;
    chk("ackcol_serv", StatPort, 8'h81, 1'b0);
    end_svc();
    chk("ackcol_idle", StatPort, 8'h01, 1'b0);
    tick(1);
    chk("ackcol_rereq", StatPort, 8'h41, 1'b1);
    ack();
    end_svc();
    chk("ackcol_done", StatPort, 8'h00, 1'b0);

    // Level held 20 cycles -> one request only
    irq = 4'b0001;
    tick(4);
    chk("level_req", StatPort, 8'h41, 1'b1);
    ack();
    end_svc();
    tick(14);
    chk("level_once", StatPort, 8'h00, 1'b0);
    irq = '0;

    // Edge during service waits for EOI
    wr(MaskPort, 8'h03);
    tick(2);
    irq = 4'b0001;
    tick(3);
    irq = '0;
    tick(1);
    ack();
    irq = 4'b0010;
    tick(3);
    chk("svc_latch", StatPort, 8'h82, 1'b0);
    irq = '0;
    tick(2);
    chk("svc_hold", StatPort, 8'h82, 1'b0);
    end_svc();
    chk("svc_eoi", StatPort, 8'h02, 1'b0);
    tick(1);
    chk("svc_rereq", StatPort, 8'h42, 1'b1);
    chk("svc_cause", CausePort, 8'h01, 1'b1);

    // Ack and EOI together in REQ: only the ack applies
    int_ack = 1'b1;
    eoi     = 1'b1;
    tick(1);
    int_ack = 1'b0;
    eoi     = 1'b0;
    chk("ack_eoi_same", StatPort, 8'h80, 1'b0);
    end_svc();
    chk("final_idle", StatPort, 8'h00, 1'b0);

    tick(1);
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL leftover: %0d expectations never checked, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
